// File: rtl/pan_capture_ctrl.sv
// pan_capture_ctrl: packs PAN digits for a Luhn validator and registers the verdict; LUHN_BACKSPACE_EN enables bksp
module pan_capture_ctrl #(
  parameter int NUM_DIGITS = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  digit_in,
  input  logic        digit_valid,
  output logic        digit_ready,
  input  logic        clear,
  input  logic        bksp,
  output logic [75:0] pan_bcd,
  output logic        pan_ready,
  input  logic        luhn_valid,
  output logic        result_valid,
  output logic        result_pass,
  output logic        error,
  output logic [1:0]  error_code,
  output logic [4:0]  digit_count,
  input  logic        result_ack
);
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [4:0] N = 5'(NUM_DIGITS);
  typedef enum logic [2:0] {IDLE, CAPTURE, CHECK, DONE, ERROR} state_t;
  state_t state;
  logic [TW-1:0] tmo_cnt;
  logic bksp_en, accept, wipe;
`ifdef LUHN_BACKSPACE_EN
  assign bksp_en = bksp;
`else
  logic unused_bksp;
  assign unused_bksp = bksp;
  assign bksp_en = 1'b0;
`endif
  assign digit_ready = (state == IDLE || state == CAPTURE) && digit_count < N && !clear && !bksp_en;
  assign accept = digit_valid && digit_ready;
  // clear and an acknowledged verdict both return to a fully zeroed IDLE
  assign wipe = clear || ((state == DONE || state == ERROR) && result_ack);
  always_ff @(posedge clk) begin
    if (rst || wipe) begin
      state <= IDLE;
      pan_bcd <= '0;
      pan_ready <= 1'b0;
      result_valid <= 1'b0;
      result_pass <= 1'b0;
      error <= 1'b0;
      error_code <= 2'd0;
      digit_count <= 5'd0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        IDLE, CAPTURE: begin
          if (state == CAPTURE && bksp_en) begin
            digit_count <= digit_count - 5'd1;
            pan_bcd[{digit_count - 5'd1, 2'b00} +: 4] <= 4'd0;
            tmo_cnt <= '0;
            if (digit_count == 5'd1) state <= IDLE;
          end else if (accept) begin
            tmo_cnt <= '0;
            if (digit_in > 4'd9) begin
              state <= ERROR;
              error <= 1'b1;
              error_code <= 2'd1;
              result_valid <= 1'b1;
              result_pass <= 1'b0;
              pan_ready <= 1'b0;
            end else begin
              pan_bcd[{digit_count, 2'b00} +: 4] <= digit_in;
              digit_count <= digit_count + 5'd1;
              state <= (digit_count + 5'd1 == N) ? CHECK : CAPTURE;
              pan_ready <= digit_count + 5'd1 == N;
            end
          end else if (state == CAPTURE && TIMEOUT_CYCLES != 0) begin
            if (tmo_cnt == TMO_LAST) begin
              state <= ERROR;
              error <= 1'b1;
              error_code <= 2'd2;
              result_valid <= 1'b1;
              result_pass <= 1'b0;
              pan_ready <= 1'b0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
        end
        CHECK: begin
          result_pass <= luhn_valid;
          result_valid <= 1'b1;
          state <= DONE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pan_capture_ctrl.sv
// tb_pan_capture_ctrl: scoreboard bench with a behavioural Luhn validator driving luhn_valid
module tb_pan_capture_ctrl;
  localparam int ND = 16;
  localparam int TMO = 20;
  logic clk = 1'b0;
  logic rst, digit_valid, digit_ready, clear, bksp, pan_ready, luhn_valid;
  logic result_valid, result_pass, error, result_ack;
  logic [3:0] digit_in;
  logic [75:0] pan_bcd;
  logic [1:0] error_code;
  logic [4:0] digit_count;
  typedef struct packed {logic pass; logic err; logic [1:0] code; logic [4:0] cnt;} exp_t;
  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic [3:0] good [ND] = '{4, 5, 3, 9, 1, 4, 8, 8, 0, 3, 4, 3, 6, 4, 6, 7};

  always #5 clk = ~clk;

  pan_capture_ctrl #(.NUM_DIGITS(ND), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .digit_in(digit_in), .digit_valid(digit_valid),
    .digit_ready(digit_ready), .clear(clear), .bksp(bksp), .pan_bcd(pan_bcd),
    .pan_ready(pan_ready), .luhn_valid(luhn_valid), .result_valid(result_valid),
    .result_pass(result_pass), .error(error), .error_code(error_code),
    .digit_count(digit_count), .result_ack(result_ack)
  );

  // last received digit is the check digit; double every second digit left of it
  function automatic logic luhn_ok(input logic [75:0] bcd);
    int sum;
    int d;
    sum = 0;
    for (int i = 0; i < ND; i++) begin
      d = int'(bcd[4*i +: 4]);
      if ((ND - 1 - i) % 2 == 1) begin
        d = 2 * d;
        if (d > 9) d -= 9;
      end
      sum += d;
    end
    return sum % 10 == 0;
  endfunction
  assign luhn_valid = luhn_ok(pan_bcd);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d);
    digit_in = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic wait_result(input string name);
    exp_t got, want;
    for (int k = 0; k < 8 && !result_valid; k++) tick();
    n_checks++;
    if (!result_valid || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_result: result_valid=%0b queued=%0d, required result_valid=1 with a queued expectation", name, result_valid, exp_q.size());
    end else begin
      want = exp_q.pop_front();
      got = {result_pass, error, error_code, digit_count};
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s_result: pass/err/code/cnt=%0b/%0b/%0d/%0d required %0b/%0b/%0d/%0d", name, got.pass, got.err, got.code, got.cnt, want.pass, want.err, want.code, want.cnt);
      end
    end
  endtask

  task automatic ack_and_check(input string name);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    n_checks++;
    if ({pan_bcd, pan_ready, result_valid, result_pass, error, error_code, digit_count} !== '0) begin
      n_fail++;
      $display("FAIL %s_ack_clear: pan_bcd=%h rdy=%0b rv=%0b rp=%0b err=%0b code=%0d cnt=%0d required all 0", name, pan_bcd, pan_ready, result_valid, result_pass, error, error_code, digit_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({pan_bcd, pan_ready, result_valid, result_pass, error, error_code, digit_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: pan_bcd=%h cnt=%0d rv=%0b err=%0b required all 0", pan_bcd, digit_count, result_valid, error);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (digit_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: digit_ready=%0b required 1", digit_ready); end
  endtask

  task automatic test_pan(input logic [3:0] last, input logic exp_pass, input string name);
    for (int i = 0; i < ND - 1; i++) send(good[i]);
    send(last);
    n_checks++;
    if (pan_ready !== 1'b1 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_pan_ready: pan_ready=%0b result_valid=%0b required 1/0", name, pan_ready, result_valid);
    end
    exp_q.push_back('{exp_pass, 1'b0, 2'd0, 5'(ND)});
    tick();
    n_checks++;
    if (result_valid !== 1'b1) begin n_fail++; $display("FAIL %s_latency: result_valid=%0b required 1", name, result_valid); end
    wait_result(name);
    n_checks++;
    if (pan_bcd[3:0] !== 4'd4 || pan_bcd[63:60] !== last || pan_bcd[75:64] !== '0) begin
      n_fail++;
      $display("FAIL %s_pan_bcd: pan_bcd=%h required [3:0]=4 [63:60]=%0d upper 0", name, pan_bcd, last);
    end
    tick();
    n_checks++;
    if (result_valid !== 1'b1 || pan_ready !== 1'b1 || result_pass !== exp_pass || digit_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_hold: rv=%0b rdy=%0b rp=%0b dr=%0b required 1/1/%0b/0", name, result_valid, pan_ready, result_pass, digit_ready, exp_pass);
    end
    ack_and_check(name);
  endtask

  task automatic test_non_bcd();
    send(4'd4);
    send(4'd5);
    exp_q.push_back('{1'b0, 1'b1, 2'd1, 5'd2});
    send(4'hA);
    n_checks++;
    if (digit_ready !== 1'b0 || pan_bcd !== 76'h54) begin
      n_fail++;
      $display("FAIL non_bcd_state: digit_ready=%0b pan_bcd=%h required 0 and 54", digit_ready, pan_bcd);
    end
    wait_result("non_bcd");
    ack_and_check("non_bcd");
  endtask

  task automatic test_timeout();
    int k;
    send(4'd1);
    send(4'd2);
    send(4'd3);
    exp_q.push_back('{1'b0, 1'b1, 2'd2, 5'd3});
    k = 0;
    while (k < 40 && !error) begin
      tick();
      k++;
    end
    n_checks++;
    if (k != TMO) begin n_fail++; $display("FAIL timeout_cycles: error after %0d edges required %0d", k, TMO); end
    wait_result("timeout");
    ack_and_check("timeout");
  endtask

  task automatic test_clear();
    for (int i = 0; i < 4; i++) send(good[i]);
    digit_in = good[4];
    digit_valid = 1'b1;
    clear = 1'b1;
    #1;
    n_checks++;
    if (digit_ready !== 1'b0) begin n_fail++; $display("FAIL clear_ready: digit_ready=%0b required 0", digit_ready); end
    tick();
    clear = 1'b0;
    digit_valid = 1'b0;
    #1;
    n_checks++;
    if (digit_count !== 5'd0 || pan_bcd !== '0 || digit_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_idle: cnt=%0d pan_bcd=%h digit_ready=%0b required 0/0/1", digit_count, pan_bcd, digit_ready);
    end
    for (int i = 0; i < ND; i++) send(good[i]);
    exp_q.push_back('{1'b1, 1'b0, 2'd0, 5'(ND)});
    wait_result("rst_done");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({pan_bcd, pan_ready, result_valid, result_pass, error, error_code, digit_count} !== '0) begin
      n_fail++;
      $display("FAIL rst_done_outputs: pan_bcd=%h rv=%0b rp=%0b cnt=%0d required all 0", pan_bcd, result_valid, result_pass, digit_count);
    end
  endtask

  task automatic test_backspace();
`ifdef LUHN_BACKSPACE_EN
    logic [75:0] want;
    logic [3:0] seq [ND];
    want = '0;
    for (int i = 0; i < ND; i++) begin
      seq[i] = (i < 2) ? 4'(i + 1) : (i == 2) ? 4'd9 : good[i];
      want[4*i +: 4] = seq[i];
    end
    send(4'd1);
    send(4'd2);
    send(4'd3);
    bksp = 1'b1;
    digit_in = 4'd5;
    digit_valid = 1'b1;
    #1;
    n_checks++;
    if (digit_ready !== 1'b0) begin n_fail++; $display("FAIL bksp_ready: digit_ready=%0b required 0", digit_ready); end
    tick();
    bksp = 1'b0;
    digit_valid = 1'b0;
    n_checks++;
    if (digit_count !== 5'd2 || pan_bcd !== 76'h21) begin
      n_fail++;
      $display("FAIL bksp_delete: cnt=%0d pan_bcd=%h required 2 and 21", digit_count, pan_bcd);
    end
    for (int i = 2; i < ND; i++) send(seq[i]);
    exp_q.push_back('{luhn_ok(want), 1'b0, 2'd0, 5'(ND)});
    n_checks++;
    if (pan_bcd !== want || pan_bcd[11:8] !== 4'd9) begin
      n_fail++;
      $display("FAIL bksp_pan: pan_bcd=%h required %h", pan_bcd, want);
    end
    wait_result("bksp");
    ack_and_check("bksp");
`else
    bksp = 1'b1;
    send(4'd1);
    send(4'd2);
    n_checks++;
    if (digit_count !== 5'd2 || pan_bcd !== 76'h21) begin
      n_fail++;
      $display("FAIL bksp_ignored: cnt=%0d pan_bcd=%h required 2 and 21", digit_count, pan_bcd);
    end
    bksp = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    digit_in = 4'd0;
    digit_valid = 1'b0;
    clear = 1'b0;
    bksp = 1'b0;
    result_ack = 1'b0;
    test_reset();
    test_pan(4'd7, 1'b1, "valid_pan");
    test_pan(4'd8, 1'b0, "invalid_pan");
    test_non_bcd();
    test_timeout();
    test_clear();
    test_backspace();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
